// File: rtl/switch_conditioner.sv
// Switch/button conditioner: per-channel 2-FF synchronizer, 4-state debounce FSM,
// registered level plus one-cycle press/release/auto-repeat strobes.
module switch_conditioner #(
    parameter int unsigned N               = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sw,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] rel,   // release strobe; "release" is a reserved word
    output logic [N-1:0] rpt
);

    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] DLAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RDLAST = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RW-1:0] RPLAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        LOW,
        RISING,
        HIGH,
        FALLING
    } state_t;

    state_t        state [N];
    logic [DW-1:0] dcnt  [N];
    logic [RW-1:0] rcnt  [N];
    logic [N-1:0]  s0;
    logic [N-1:0]  s1;
    logic [N-1:0]  first;   // repeat timer is still waiting out the initial delay

    always_ff @(posedge clk) begin
        if (reset) begin
            s0    <= '0;
            s1    <= '0;
            level <= '0;
            press <= '0;
            rel   <= '0;
            rpt   <= '0;
            first <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                state[i] <= LOW;
                dcnt[i]  <= '0;
                rcnt[i]  <= '0;
            end
        end else begin
            s0    <= sw;
            s1    <= s0;
            press <= '0;
            rel   <= '0;
            rpt   <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                case (state[i])
                    LOW: begin
                        if (s1[i]) begin
                            state[i] <= RISING;
                            dcnt[i]  <= '0;
                        end
                    end
                    RISING: begin
                        if (!s1[i]) begin
                            state[i] <= LOW;
                        end else if (dcnt[i] == DLAST) begin
                            state[i] <= HIGH;
                            level[i] <= 1'b1;
                            press[i] <= 1'b1;
                            rcnt[i]  <= '0;
                            first[i] <= 1'b1;
                        end else begin
                            dcnt[i] <= dcnt[i] + 1'b1;
                        end
                    end
                    HIGH: begin
                        if (!s1[i]) begin
                            state[i] <= FALLING;
                            dcnt[i]  <= '0;
                        end else if (REPEAT_DELAY != 0) begin
                            // Reload on each strobe so the period never drifts
                            if (rcnt[i] == (first[i] ? RDLAST : RPLAST)) begin
                                rpt[i]   <= 1'b1;
                                rcnt[i]  <= '0;
                                first[i] <= 1'b0;
                            end else begin
                                rcnt[i] <= rcnt[i] + 1'b1;
                            end
                        end
                    end
                    FALLING: begin
                        if (s1[i]) begin
                            state[i] <= HIGH;
                            rcnt[i]  <= '0;
                            first[i] <= 1'b1;
                        end else if (dcnt[i] == DLAST) begin
                            state[i] <= LOW;
                            level[i] <= 1'b0;
                            rel[i]   <= 1'b1;
                        end else begin
                            dcnt[i] <= dcnt[i] + 1'b1;
                        end
                    end
                    default: state[i] <= LOW;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench for switch_conditioner: per-cycle expected outputs are queued when
// stimulus is driven and compared against the DUT on the falling edge.
module tb_switch_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] rpt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] rpt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    switch_conditioner #(
        .N(4),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw(sw),
        .level(level),
        .press(press),
        .rel(rel),
        .rpt(rpt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [3:0] l, input logic [3:0] p,
                        input logic [3:0] r, input logic [3:0] t);
        exp_t e;
        e.cyc   = c;
        e.level = l;
        e.press = p;
        e.rel   = r;
        e.rpt   = t;
        sb.push_back(e);
    endtask

    task automatic push_quiet(input int a, input int b, input logic [3:0] l);
        for (int c = a; c <= b; c++) push(c, l, 4'h0, 4'h0, 4'h0);
    endtask

    // Returns just after the active edge that brought cyc up to c
    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            check_eq("level",   {28'h0, level}, {28'h0, mon_e.level});
            check_eq("press",   {28'h0, press}, {28'h0, mon_e.press});
            check_eq("release", {28'h0, rel},   {28'h0, mon_e.rel});
            check_eq("rpt",     {28'h0, rpt},   {28'h0, mon_e.rpt});
        end
    end

    initial begin
        logic [3:0] r;
        reset = 1'b1;
        sw    = 4'hF;

        // Reset with all switches high, then all qualify together
        push_quiet(1, 9, 4'h0);
        push(10, 4'hF, 4'hF, 4'h0, 4'h0);
        push_quiet(11, 12, 4'hF);
        at_cycle(3);
        reset = 1'b0;
        at_cycle(12);
        sw = 4'h0;
        push_quiet(13, 18, 4'hF);
        push(19, 4'h0, 4'h0, 4'hF, 4'h0);
        push_quiet(20, 25, 4'h0);

        // Single channel press and release
        at_cycle(25);
        sw = 4'h1;
        push_quiet(26, 31, 4'h0);
        push(32, 4'h1, 4'h1, 4'h0, 4'h0);
        push_quiet(33, 35, 4'h1);
        at_cycle(35);
        sw = 4'h0;
        push_quiet(36, 41, 4'h1);
        push(42, 4'h0, 4'h0, 4'h1, 4'h0);
        push_quiet(43, 45, 4'h0);

        // Short pulse and fast toggling on ch2 must be rejected
        at_cycle(45);
        sw = 4'h4;
        push_quiet(46, 110, 4'h0);
        at_cycle(48);
        sw = 4'h0;
        at_cycle(55);
        for (int i = 0; i < 20; i++) begin
            sw[2] = ~sw[2];
            at_cycle(cyc + 2);
        end

        // ch1 held: repeat train, glitch restarting the delay, then release
        at_cycle(110);
        sw = 4'h2;
        push_quiet(111, 116, 4'h0);
        push(117, 4'h2, 4'h2, 4'h0, 4'h0);
        for (int c = 118; c <= 176; c++) begin
            r = (c == 127 || c == 132 || c == 137 || c == 142 || c == 147 ||
                 c == 152 || c == 165 || c == 170) ? 4'h2 : 4'h0;
            push(c, 4'h2, 4'h0, 4'h0, r);
        end
        push(177, 4'h0, 4'h0, 4'h2, 4'h0);
        push_quiet(178, 185, 4'h0);
        at_cycle(150);
        sw = 4'h0;
        at_cycle(152);
        sw = 4'h2;
        at_cycle(170);
        sw = 4'h0;

        // ch3: reset during RISING, reset while HIGH, then simultaneous presses
        at_cycle(185);
        sw = 4'h8;
        push_quiet(186, 196, 4'h0);
        push(197, 4'h8, 4'h8, 4'h0, 4'h0);
        push_quiet(198, 200, 4'h8);
        push_quiet(201, 207, 4'h0);
        push(208, 4'h8, 4'h8, 4'h0, 4'h0);
        push_quiet(209, 217, 4'h8);
        push(218, 4'h8, 4'h0, 4'h0, 4'h8);
        push(219, 4'hF, 4'h7, 4'h0, 4'h0);
        push_quiet(220, 222, 4'hF);
        push(223, 4'hF, 4'h0, 4'h0, 4'h8);
        at_cycle(189);
        reset = 1'b1;
        at_cycle(190);
        reset = 1'b0;
        at_cycle(200);
        reset = 1'b1;
        at_cycle(201);
        reset = 1'b0;
        at_cycle(212);
        sw = 4'hF;

        at_cycle(226);
        check_eq("sb_drain", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
